// File: rtl/apc_stream_accumulator.sv
// apc_stream_accumulator
// Sums the per-cycle counts of a 16-input approximate parallel counter over one
// stochastic bit-stream frame of STREAM_LEN accepted beats. Each frame total is
// presented on a registered valid/ready result port.
module apc_stream_accumulator #(
  parameter int unsigned STREAM_LEN = 256,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned ACC_W      = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       cnt_in,
  input  logic             cnt_valid,
  output logic             busy,
  output logic [ACC_W-1:0] res_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             err
);

  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(16);
  localparam logic [LEN_W-1:0] LAST_BEAT = LEN_W'(STREAM_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic               err_q, err_d;
  logic [ACC_W-1:0]   res_sum_q, res_sum_d;
  logic               res_valid_q, res_valid_d;
  logic               busy_q, busy_d;

  logic               cnt_illegal;
  logic [CNT_W-1:0]   cnt_clamped;
  logic [ACC_W-1:0]   acc_sum;

  // Saturate out-of-range counts at 16 and form the running sum with this beat
  always_comb begin
    cnt_illegal = (cnt_in > CNT_MAX);
    cnt_clamped = cnt_illegal ? CNT_MAX : cnt_in;
    acc_sum     = acc_q + ACC_W'(cnt_clamped);
  end

  // Next-state and datapath control for the IDLE / ACC / HOLD frame sequencer
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beat_d      = beat_q;
    err_d       = err_q;
    res_sum_d   = res_sum_q;
    res_valid_d = res_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        // Beats arriving before a frame starts are dropped, not buffered.
        if (start) begin
          state_d = ST_ACC;
          acc_d   = '0;
          beat_d  = '0;
          err_d   = 1'b0;
        end
      end

      ST_ACC: begin
        // Stalls (cnt_valid=0) simply hold; start is ignored mid-frame.
        if (cnt_valid) begin
          acc_d  = acc_sum;
          beat_d = beat_q + LEN_W'(1);
          if (cnt_illegal) begin
            err_d = 1'b1;
          end
          if (beat_q == LAST_BEAT) begin
            state_d     = ST_HOLD;
            res_sum_d   = acc_sum;
            res_valid_d = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        // Result is never overwritten: a new frame may only start on the handshake.
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (start) begin
            state_d = ST_ACC;
            acc_d   = '0;
            beat_d  = '0;
            err_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        res_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d == ST_ACC);
  end

  // State and output registers with synchronous reset; a reset mid-frame discards it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      res_sum_q   <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      res_sum_q   <= res_sum_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign res_sum   = res_sum_q;
  assign res_valid = res_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_apc_stream_accumulator.sv
// Directed self-checking bench for apc_stream_accumulator (STREAM_LEN=256).
module tb_apc_stream_accumulator;

  localparam int unsigned STREAM_LEN = 256;
  localparam int unsigned LEN_W      = 8;
  localparam int unsigned ACC_W      = 13;

  logic             clk;
  logic             rst;
  logic             start;
  logic [4:0]       cnt_in;
  logic             cnt_valid;
  logic             busy;
  logic [ACC_W-1:0] res_sum;
  logic             res_valid;
  logic             res_ready;
  logic             err;

  int checks;
  int failures;

  apc_stream_accumulator #(
    .STREAM_LEN(STREAM_LEN),
    .LEN_W     (LEN_W),
    .ACC_W     (ACC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cnt_in   (cnt_in),
    .cnt_valid(cnt_valid),
    .busy     (busy),
    .res_sum  (res_sum),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive n back-to-back beats of value v
  task automatic run_frame(input int n, input logic [4:0] v);
    for (int i = 0; i < n; i++) begin
      cnt_valid = 1'b1;
      cnt_in    = v;
      tick();
    end
    cnt_valid = 1'b0;
    cnt_in    = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", busy); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%0d exp=0", res_valid); end
    checks++; if (res_sum !== 13'd0) begin failures++; $display("FAIL reset_res_sum got=%0d exp=0", res_sum); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0d exp=0", err); end
  endtask

  task automatic test_full_scale();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_busy_after_start got=%0d exp=1", busy); end
    for (int i = 0; i < 256; i++) begin
      cnt_valid = 1'b1;
      cnt_in    = 5'd16;
      tick();
      if (i == 254) begin
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL full_early_valid got=%0d exp=0", res_valid); end
      end
    end
    cnt_valid = 1'b0;
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL full_res_valid got=%0d exp=1", res_valid); end
    checks++; if (res_sum !== 13'd4096) begin failures++; $display("FAIL full_res_sum got=%0d exp=4096", res_sum); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL full_err got=%0d exp=0", err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_busy_hold got=%0d exp=0", busy); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL full_handshake_valid got=%0d exp=0", res_valid); end
    checks++; if (res_sum !== 13'd4096) begin failures++; $display("FAIL full_sum_held got=%0d exp=4096", res_sum); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_idle_busy got=%0d exp=0", busy); end
  endtask

  task automatic test_gaps();
    int gap_bad;
    gap_bad = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if ((i % 3) == 2) begin
        cnt_valid = 1'b0;
        cnt_in    = 5'd16;
        tick();
        if (busy !== 1'b1) gap_bad++;
      end
      cnt_valid = 1'b1;
      cnt_in    = (i % 2 == 1) ? 5'd8 : 5'd0;
      tick();
    end
    cnt_valid = 1'b0;
    checks++; if (gap_bad !== 0) begin failures++; $display("FAIL gaps_busy_low got=%0d exp=0", gap_bad); end
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL gaps_res_valid got=%0d exp=1", res_valid); end
    checks++; if (res_sum !== 13'd1024) begin failures++; $display("FAIL gaps_res_sum got=%0d exp=1024", res_sum); end
  endtask

  task automatic test_back_to_back();
    int hold_bad;
    hold_bad = 0;
    for (int k = 0; k < 10; k++) begin
      res_ready = 1'b0;
      start     = (k == 3 || k == 4);
      cnt_valid = 1'b1;
      cnt_in    = 5'd16;
      tick();
      if (res_valid !== 1'b1 || res_sum !== 13'd1024 || busy !== 1'b0) hold_bad++;
    end
    start     = 1'b0;
    cnt_valid = 1'b0;
    checks++; if (hold_bad !== 0) begin failures++; $display("FAIL hold_result_disturbed got=%0d exp=0", hold_bad); end
    res_ready = 1'b1;
    start     = 1'b1;
    tick();
    res_ready = 1'b0;
    start     = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%0d exp=1", busy); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL b2b_res_valid got=%0d exp=0", res_valid); end
    run_frame(256, 5'd1);
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL b2b_frame_valid got=%0d exp=1", res_valid); end
    checks++; if (res_sum !== 13'd256) begin failures++; $display("FAIL b2b_res_sum got=%0d exp=256", res_sum); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_clamp();
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt_valid = 1'b1;
    cnt_in    = 5'd31;
    tick();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL clamp_err_set got=%0d exp=1", err); end
    run_frame(255, 5'd0);
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL clamp_res_valid got=%0d exp=1", res_valid); end
    checks++; if (res_sum !== 13'd16) begin failures++; $display("FAIL clamp_res_sum got=%0d exp=16", res_sum); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL clamp_err_hold got=%0d exp=1", err); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL clamp_err_idle got=%0d exp=1", err); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL clamp_err_cleared got=%0d exp=0", err); end
    run_frame(256, 5'd0);
    checks++; if (res_sum !== 13'd0) begin failures++; $display("FAIL clamp_zero_frame got=%0d exp=0", res_sum); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_frame(100, 5'd2);
    rst       = 1'b1;
    cnt_valid = 1'b1;
    cnt_in    = 5'd2;
    tick();
    rst       = 1'b0;
    cnt_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0d exp=0", busy); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rstmid_res_valid got=%0d exp=0", res_valid); end
    checks++; if (res_sum !== 13'd0) begin failures++; $display("FAIL rstmid_res_sum got=%0d exp=0", res_sum); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_stays_idle got=%0d exp=0", busy); end
    start = 1'b1;
    tick();
    start = 1'b0;
    run_frame(256, 5'd2);
    checks++; if (res_sum !== 13'd512) begin failures++; $display("FAIL rstmid_fresh_sum got=%0d exp=512", res_sum); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_idle_beats();
    int idle_bad;
    idle_bad = 0;
    for (int k = 0; k < 20; k++) begin
      cnt_valid = 1'b1;
      cnt_in    = 5'd16;
      tick();
      if (busy !== 1'b0 || res_valid !== 1'b0) idle_bad++;
    end
    checks++; if (idle_bad !== 0) begin failures++; $display("FAIL idle_activity got=%0d exp=0", idle_bad); end
    start = 1'b1;
    tick();
    start = 1'b0;
    run_frame(256, 5'd1);
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL idle_frame_valid got=%0d exp=1", res_valid); end
    checks++; if (res_sum !== 13'd256) begin failures++; $display("FAIL idle_frame_sum got=%0d exp=256", res_sum); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL idle_final_handshake got=%0d exp=0", res_valid); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    cnt_in    = 5'd0;
    cnt_valid = 1'b0;
    res_ready = 1'b0;
    test_reset();
    test_full_scale();
    test_gaps();
    test_back_to_back();
    test_clamp();
    test_reset_mid_frame();
    test_idle_beats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run can never hang
  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=expired exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
